// File: rtl/ctr_seq_pkg.sv
// Shared types and constants for the dual-counter burst sequencer/arbiter.
package ctr_seq_pkg;

  localparam int STEP_W_DEF = 4;
  localparam int MAX_REQ    = 4;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    RUN,
    DONE,
    ABORT
  } state_t;

  // A programmed length of 0 stands for the full 2**w steps.
  function automatic int unsigned len_decode(input int unsigned len, input int unsigned w);
    return (len == 0) ? (32'd1 << w) : len;
  endfunction

endpackage

// File: rtl/ctr_seq_rr_arb.sv
// Combinational winner select: round-robin from ptr (inclusive), or fixed
// lowest-index priority when CTR_SEQ_FIXED_PRIO_EN is defined.
module ctr_seq_rr_arb #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic               win_vld,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [1:0]         win_idx
);

`ifdef CTR_SEQ_FIXED_PRIO_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    win_vld = 1'b0;
    win_oh  = '0;
    win_idx = 2'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!win_vld && req[i]) begin
        win_vld    = 1'b1;
        win_oh[i]  = 1'b1;
        win_idx    = 2'(i);
      end
    end
  end
`else
  logic [2:0] cand;

  always_comb begin
    win_vld = 1'b0;
    win_oh  = '0;
    win_idx = 2'd0;
    cand    = 3'd0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, ptr} + 3'(i);
      if (cand >= 3'(NUM_REQ)) cand = cand - 3'(NUM_REQ);
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!win_vld && (cand == 3'(j)) && req[j]) begin
          win_vld   = 1'b1;
          win_oh[j] = 1'b1;
          win_idx   = 2'(j);
        end
      end
    end
  end
`endif

endmodule

// File: rtl/ctr_seq_arbiter.sv
// Burst sequencer/arbiter for the shared step/accumulate counter datapath.
// Build option: CTR_SEQ_FIXED_PRIO_EN selects fixed priority (no rr pointer).
//
//   state | meaning
//   IDLE  | no owner; arbitrate and latch winner's length/increment
//   SETUP | grant raised, datapath cleared
//   RUN   | one datapath step per cycle until remaining count hits 1
//   DONE  | completion pulse, grant still held
//   ABORT | owner dropped req mid-burst; grant released
module ctr_seq_arbiter
  import ctr_seq_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int STEP_W  = STEP_W_DEF
) (
  input  logic                      clk,
  input  logic                      clear_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*STEP_W-1:0] req_len,
  input  logic [NUM_REQ*STEP_W-1:0] req_inc,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [1:0]                owner,
  output logic                      busy,
  output logic                      ctr_clear,
  output logic                      ctr_step,
  output logic [STEP_W-1:0]         ctr_two_inc,
  output logic                      done,
  output logic                      abort
);

  state_t              state_q, state_d;
  logic [1:0]          owner_q, owner_d;
  logic [NUM_REQ-1:0]  oh_q, oh_d;
  logic [STEP_W:0]     rem_q, rem_d;
  logic [STEP_W-1:0]   inc_q, inc_d;

  logic                win_vld;
  logic [NUM_REQ-1:0]  win_oh;
  logic [1:0]          win_idx;
  logic [1:0]          arb_ptr;
  logic [STEP_W-1:0]   sel_len, sel_inc;
  logic                owner_req;
  logic                granted;

  ctr_seq_rr_arb #(.NUM_REQ(NUM_REQ)) u_arb (
    .req     (req),
    .ptr     (arb_ptr),
    .win_vld (win_vld),
    .win_oh  (win_oh),
    .win_idx (win_idx)
  );

`ifdef CTR_SEQ_FIXED_PRIO_EN
  assign arb_ptr = 2'd0;
`else
  logic [1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == DONE || state_q == ABORT)
      ptr_d = (owner_q == 2'(NUM_REQ-1)) ? 2'd0 : owner_q + 2'd1;
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) ptr_q <= 2'd0;
    else          ptr_q <= ptr_d;
  end

  assign arb_ptr = ptr_q;
`endif

  always_comb begin
    sel_len = '0;
    sel_inc = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_oh[i]) begin
        sel_len = req_len[i*STEP_W +: STEP_W];
        sel_inc = req_inc[i*STEP_W +: STEP_W];
      end
    end
  end

  assign owner_req = |(req & oh_q);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    oh_d    = oh_q;
    rem_d   = rem_q;
    inc_d   = inc_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          owner_d = win_idx;
          oh_d    = win_oh;
          rem_d   = (STEP_W+1)'(len_decode(32'(sel_len), STEP_W));
          inc_d   = sel_inc;
          state_d = SETUP;
        end
      end
      SETUP: state_d = owner_req ? RUN : ABORT;
      RUN: begin
        rem_d = rem_q - {{STEP_W{1'b0}}, 1'b1};
        if (!owner_req)                             state_d = ABORT;
        else if (rem_q == {{STEP_W{1'b0}}, 1'b1})   state_d = DONE;
      end
      DONE:    state_d = IDLE;
      ABORT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q <= IDLE;
      owner_q <= 2'd0;
      oh_q    <= '0;
      rem_q   <= '0;
      inc_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      oh_q    <= oh_d;
      rem_q   <= rem_d;
      inc_q   <= inc_d;
    end
  end

  // Moore outputs; async reset forces IDLE, so these drop without a clock.
  always_comb begin
    granted     = (state_q == SETUP) || (state_q == RUN) || (state_q == DONE);
    gnt         = granted ? oh_q : '0;
    owner       = granted ? owner_q : 2'd0;
    busy        = (state_q != IDLE);
    ctr_clear   = (state_q == SETUP);
    ctr_step    = (state_q == RUN);
    ctr_two_inc = (state_q == RUN) ? inc_q : '0;
    done        = (state_q == DONE);
    abort       = (state_q == ABORT);
  end

endmodule

// File: tb/tb_ctr_seq_arbiter.sv
// Scoreboard bench for ctr_seq_arbiter: directed bursts push expected
// grant/done/abort events; a negedge monitor pops and compares them.
module tb_ctr_seq_arbiter;

  localparam int EV_GNT = 0;
  localparam int EV_DONE = 1;
  localparam int EV_ABORT = 2;

  logic       clk;
  logic       clear_n;
  logic [1:0] req;
  logic [7:0] req_len;
  logic [7:0] req_inc;
  logic [1:0] gnt;
  logic [1:0] owner;
  logic       busy, ctr_clear, ctr_step, done, abort;
  logic [3:0] ctr_two_inc;

  typedef struct {
    int kind;
    int own;
    int cyc;
    int steps;
    int inc;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc = 0;

  ctr_seq_arbiter #(.NUM_REQ(2), .STEP_W(4)) dut (
    .clk         (clk),
    .clear_n     (clear_n),
    .req         (req),
    .req_len     (req_len),
    .req_inc     (req_inc),
    .gnt         (gnt),
    .owner       (owner),
    .busy        (busy),
    .ctr_clear   (ctr_clear),
    .ctr_step    (ctr_step),
    .ctr_two_inc (ctr_two_inc),
    .done        (done),
    .abort       (abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int own, input int c, input int steps, input int inc);
    exp_t e;
    e.kind = kind; e.own = own; e.cyc = c; e.steps = steps; e.inc = inc;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset(input bit check_outs);
    @(negedge clk);
    clear_n = 1'b0;
    #1;
    if (check_outs) begin
      chk("rst_gnt", int'(gnt), 0);
      chk("rst_owner", int'(owner), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_ctr_clear", int'(ctr_clear), 0);
      chk("rst_ctr_step", int'(ctr_step), 0);
      chk("rst_done", int'(done), 0);
    end
    @(negedge clk);
    clear_n = 1'b1;
  endtask

  // Monitor: pop one expectation per observed grant edge / done / abort.
  initial begin
    int   step_cnt = 0;
    int   last_inc = 0;
    logic [1:0] prev_gnt = 2'b00;
    exp_t e;
    forever begin
      @(negedge clk);
      if (ctr_clear) step_cnt = 0;
      if (ctr_step) begin
        step_cnt++;
        last_inc = int'(ctr_two_inc);
      end else begin
        chk("inc_zero_when_idle", int'(ctr_two_inc), 0);
      end
      if ((gnt != 2'b00 && prev_gnt == 2'b00) || done || abort) begin
        if (q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_event: got gnt=%0d done=%0d abort=%0d required no event (cycle %0d)",
                   gnt, done, abort, cyc);
        end else begin
          e = q.pop_front();
          if (done) begin
            chk("ev_kind", EV_DONE, e.kind);
            chk("done_cycle", cyc, e.cyc);
            chk("done_owner", int'(owner), e.own);
            chk("done_steps", step_cnt, e.steps);
            chk("done_inc", last_inc, e.inc);
          end else if (abort) begin
            chk("ev_kind", EV_ABORT, e.kind);
            chk("abort_cycle", cyc, e.cyc);
            chk("abort_steps", step_cnt, e.steps);
            chk("abort_gnt", int'(gnt), 0);
          end else begin
            chk("ev_kind", EV_GNT, e.kind);
            chk("gnt_cycle", cyc, e.cyc);
            chk("gnt_owner", int'(owner), e.own);
            chk("gnt_onehot", int'(gnt), 1 << e.own);
            chk("gnt_clear", int'(ctr_clear), 1);
          end
        end
      end
      prev_gnt = gnt;
    end
  end

  initial begin
    int c0;
    clear_n = 1'b1;
    req     = 2'b00;
    req_len = 8'h00;
    req_inc = 8'h00;
    #2;
    do_reset(1'b1);

    // single burst: len 3, inc 2
    @(negedge clk);
    c0 = cyc;
    req = 2'b01; req_len = {4'd0, 4'd3}; req_inc = {4'd0, 4'd2};
    push(EV_GNT, 0, c0 + 1, 0, 0);
    push(EV_DONE, 0, c0 + 5, 3, 2);
    tick(5);
    req = 2'b00;
    tick(1);
    chk("t1_busy_after", int'(busy), 0);
    chk("t1_gnt_after", int'(gnt), 0);

    do_reset(1'b0);

`ifdef CTR_SEQ_FIXED_PRIO_EN
    // fixed priority: requester 0 wins every burst
    @(negedge clk);
    c0 = cyc;
    req = 2'b11; req_len = {4'd1, 4'd2}; req_inc = {4'd3, 4'd1};
    push(EV_GNT, 0, c0 + 1, 0, 0);
    push(EV_DONE, 0, c0 + 4, 2, 1);
    push(EV_GNT, 0, c0 + 6, 0, 0);
    push(EV_DONE, 0, c0 + 9, 2, 1);
    push(EV_GNT, 0, c0 + 11, 0, 0);
    push(EV_DONE, 0, c0 + 14, 2, 1);
    tick(14);
    req = 2'b00;
    tick(2);
`else
    // both requesting, lengths 1 and 2: owner 0,1,0 with periods 4 and 5
    @(negedge clk);
    c0 = cyc;
    req = 2'b11; req_len = {4'd2, 4'd1}; req_inc = {4'd3, 4'd1};
    push(EV_GNT, 0, c0 + 1, 0, 0);
    push(EV_DONE, 0, c0 + 3, 1, 1);
    push(EV_GNT, 1, c0 + 5, 0, 0);
    push(EV_DONE, 1, c0 + 8, 2, 3);
    push(EV_GNT, 0, c0 + 10, 0, 0);
    push(EV_DONE, 0, c0 + 12, 1, 1);
    tick(12);
    req = 2'b00;
    tick(2);
`endif

    // length 0 means 16 steps
    @(negedge clk);
    c0 = cyc;
    req = 2'b10; req_len = {4'd0, 4'd9}; req_inc = {4'd5, 4'd0};
    push(EV_GNT, 1, c0 + 1, 0, 0);
    push(EV_DONE, 1, c0 + 18, 16, 5);
    tick(18);
    req = 2'b00;
    tick(2);

    // owner 0 drops req on the 2nd RUN cycle; requester 1 follows
    @(negedge clk);
    c0 = cyc;
    req = 2'b11; req_len = {4'd2, 4'd5}; req_inc = {4'd1, 4'd4};
    push(EV_GNT, 0, c0 + 1, 0, 0);
    push(EV_ABORT, 0, c0 + 4, 2, 0);
    push(EV_GNT, 1, c0 + 6, 0, 0);
    push(EV_DONE, 1, c0 + 9, 2, 1);
    tick(3);
    req = 2'b10;
    tick(6);
    req = 2'b00;
    tick(2);

`ifndef CTR_SEQ_FIXED_PRIO_EN
    // async reset during requester 1's RUN; afterwards requester 0 wins first
    @(negedge clk);
    c0 = cyc;
    req = 2'b11; req_len = {4'd4, 4'd1}; req_inc = {4'd7, 4'd2};
    push(EV_GNT, 0, c0 + 1, 0, 0);
    push(EV_DONE, 0, c0 + 3, 1, 2);
    push(EV_GNT, 1, c0 + 5, 0, 0);
    tick(7);
    chk("t5_step_before_rst", int'(ctr_step), 1);
    #2;
    clear_n = 1'b0;
    #1;
    chk("t5_async_gnt", int'(gnt), 0);
    chk("t5_async_step", int'(ctr_step), 0);
    chk("t5_async_busy", int'(busy), 0);
    req_len = {4'd4, 4'd2}; req_inc = {4'd7, 4'd3};
    tick(2);
    clear_n = 1'b1;
    c0 = cyc;
    push(EV_GNT, 0, c0 + 1, 0, 0);
    push(EV_DONE, 0, c0 + 4, 2, 3);
    tick(4);
    req = 2'b00;
    tick(2);
`endif

    tick(3);
    chk("queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/ctr_seq_arbiter.md
# ctr_seq_arbiter

Sequencer and arbiter for the shared dual-counter datapath (4-bit step counter plus 4-bit accumulating counter). Up to NUM_REQ requesters ask for a burst of counter steps with a per-step increment. The block grants one requester at a time, round-robin. For each burst it clears the datapath, steps it the requested number of times, then signals completion.

## Interface
- NUM_REQ, 2: number of requesters; legal range 2..4.
- STEP_W, 4: width of burst length, increment and datapath counters.
- clk  in  1  clock; all state changes on the rising edge.
- clear_n  in  1  asynchronous active-low reset.
- req  in  NUM_REQ  request per requester; level, held until done or abandoned.
- req_len  in  NUM_REQ*STEP_W  burst length per requester, slice i = requester i; 0 means 16 steps.
- req_inc  in  NUM_REQ*STEP_W  increment applied to the accumulating counter on each step.
- gnt  out  NUM_REQ  one-hot grant; all zero when idle.
- owner  out  2  index of the granted requester; 0 when idle.
- busy  out  1  high in every state except IDLE.
- ctr_clear  out  1  synchronous clear to the datapath.
- ctr_step  out  1  step enable to the datapath.
- ctr_two_inc  out  STEP_W  increment to the datapath; 0 unless ctr_step=1.
- done  out  1  single-cycle pulse at successful burst end.
- abort  out  1  single-cycle pulse when the owner drops req mid-burst.

## Operation
- Reset (clear_n=0, asynchronous): state IDLE, rr pointer 0, all outputs 0, latched length/increment 0.
- States: IDLE, SETUP, RUN, DONE, ABORT. All outputs are decoded from registered state (Moore).
- IDLE: if any req bit is set, select a winner (round-robin from the pointer, inclusive). Latch its req_len (0→16, held in a STEP_W+1-bit remaining counter) and its req_inc. Go to SETUP.
- SETUP: gnt[owner]=1, ctr_clear=1. Go to RUN.
- RUN: ctr_step=1, ctr_two_inc=latched inc. Remaining counter decrements each cycle. When it reaches 1 this cycle, go to DONE.
- DONE: done=1, gnt still held. Pointer becomes owner+1, wrapping modulo NUM_REQ. Go to IDLE.
- ABORT: if req[owner]=0 is sampled in SETUP or RUN, enter ABORT instead of the normal next state; the step in that cycle still executes. In ABORT: abort=1, gnt=0, ctr_step=0. Pointer becomes owner+1. Go to IDLE.
- req_len and req_inc are sampled only in IDLE. Changes after the grant are ignored.
- Requests from non-owners are ignored until IDLE.
- Simultaneous requests are resolved by the pointer only. There is no starvation: every requester waits at most NUM_REQ-1 bursts.

## Timing
- Cycle 0: req seen in IDLE. Cycle 1: SETUP (gnt rises, ctr_clear=1).
- Cycles 2..L+1: RUN, where L = effective length (1..16).
- Cycle L+2: DONE (done=1).
- Cycle L+3: IDLE (gnt=0, busy=0); a pending req is sampled here. Back-to-back bursts therefore repeat every L+3 cycles.
- Req-to-grant latency: exactly 1 cycle.
- Done-to-next-grant: 2 cycles.
- Reset asserted mid-burst: outputs go to 0 immediately (asynchronously). After release, state is IDLE and pointer is 0.

## Configuration
- CTR_SEQ_FIXED_PRIO_EN defined: the arbiter is fixed priority, lowest index wins. The pointer register is removed and done/abort do not update it.
- CTR_SEQ_FIXED_PRIO_EN not defined: round-robin as described above.

## Structure
- Package ctr_seq_pkg holds:
  - the state typedef (IDLE, SETUP, RUN, DONE, ABORT);
  - the STEP_W default;
  - the MAX_REQ=4 constant;
  - the length-decode helper (0→16).
- Sub-module ctr_seq_rr_arb: combinational winner select from req and pointer, with a one-hot and index output. It also hosts the fixed-priority variant under the macro.

## Test plan
- Reset, then req=01, len0=3, inc0=2 → gnt=01 at cycle 1, ctr_clear at cycle 1, ctr_step for cycles 2–4 with ctr_two_inc=2, done at cycle 5, busy=0 at cycle 6.
- req=11 held continuously, lengths 1 and 2 → grants alternate 01,10,01. Burst periods are 4 and 5 cycles. owner sequence is 0,1,0.
- req_len=0 → exactly 16 ctr_step cycles, then done.
- Owner drops req on the 2nd RUN cycle → that step still occurs, abort pulses the next cycle, no done, and the other requester is granted 2 cycles later.
- clear_n pulsed low during RUN → gnt, ctr_step and busy go 0 without waiting for clk. After release with req=11, requester 0 wins first.
- With CTR_SEQ_FIXED_PRIO_EN and req=11 held → requester 0 is granted every burst and requester 1 is never granted.
